tx_mod_core: RTL
================

TX_MOD_CORE -- requirements
Module: tx_mod_core

Interface
REQ-001 SHALL have parameter IN_W, default 12, baseband sample width (signed).
REQ-002 SHALL have parameter OUT_W, default 14, DAC output width (signed); OUT_W >= IN_W.
REQ-003 SHALL have parameter PHASE_W, default 24, NCO phase accumulator width.
REQ-004 SHALL have parameter LUT_AW, default 8, sine table address width; table holds 2^LUT_AW signed OUT_W entries.
REQ-005 SHALL have parameter DEPTH_W, default 4, modulation depth control width.
REQ-006 SHALL have parameter FM_SHIFT, default 4, left shift applied to the baseband in FM mode.
REQ-007 SHALL have port clock  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port io_ctrl_valid  input  1  config request.
REQ-010 SHALL have port io_ctrl_ready  output  1  config slot free.
REQ-011 SHALL have port io_ctrl_mode  input  2  0 bypass, 1 AM, 2 DSB, 3 FM.
REQ-012 SHALL have port io_ctrl_depth  input  DEPTH_W  depth d, unsigned.
REQ-013 SHALL have port io_ctrl_fword  input  PHASE_W  carrier frequency word.
REQ-014 SHALL have port io_in_valid  input  1  new baseband sample present.
REQ-015 SHALL have port io_in_value  input  IN_W  signed baseband sample.
REQ-016 SHALL have port io_out_valid  output  1  pipeline-filled flag.
REQ-017 SHALL have port io_out_value  output  OUT_W  signed DAC sample.

Function
REQ-018 SHALL accept config on io_ctrl_valid && io_ctrl_ready into shadow registers; io_ctrl_ready SHALL deassert the following cycle while the shadow is pending.
REQ-019 SHALL apply the pending shadow to the active config in the cycle after a phase-accumulator wrap (carry out of PHASE_W). An accept and a wrap in the same cycle defer application to the next wrap. If the active fword is 0, the pending shadow SHALL apply on the next cycle. io_ctrl_ready SHALL reassert the cycle after the shadow applies.
REQ-020 SHALL latch io_in_value into the sample register when io_in_valid is high, otherwise hold the last sample.
REQ-021 SHALL compute m = (sample * d) >>> DEPTH_W (arithmetic shift).
REQ-022 SHALL advance the phase every cycle, modulo 2^PHASE_W, by fword. In FM the increment SHALL be fword + (sign-extended m << FM_SHIFT).
REQ-023 SHALL form the carrier c from the LUT addressed by phase[PHASE_W-1 -: LUT_AW], with entry k = round((2^(OUT_W-1)-1)*sin(2*pi*k/2^LUT_AW)).
REQ-024 SHALL produce in bypass mode: out = sample << (OUT_W-IN_W).
REQ-025 SHALL produce in AM mode: out = (c * (2^(IN_W-1) + m)) >>> IN_W.
REQ-026 SHALL produce in DSB mode: out = (c * m) >>> (IN_W-1).
REQ-027 SHALL produce in FM mode: out = c.
REQ-028 SHALL saturate every mode result to [-2^(OUT_W-1), 2^(OUT_W-1)-1], with no wrap.
REQ-029 SHALL have a fixed latency of 4 cycles from a sample-register update to the io_out_value it affects: stage 1 sample/m, stage 2 phase/LUT read, stage 3 multiply, stage 4 shift/saturate/register.
REQ-030 SHALL free-run the pipeline every cycle with no output backpressure. io_out_valid SHALL rise 4 cycles after reset deassertion and stay high.

Reset
REQ-031 SHALL on reset force: phase=0, sample=0, active and shadow mode=0, depth=0, fword=0, pipeline registers=0, io_out_value=0, io_out_valid=0, io_ctrl_ready=1.
REQ-032 SHALL on reset asserted mid-operation clear all state immediately, discarding any pending shadow; operation resumes from the REQ-031 state.

Verification
REQ-033 SHALL cover: reset release, config mode 0 accepted, in=0x7FF held -> io_out_value=0x1FFC exactly 4 cycles after the sample latch; io_out_valid low for the first 4 cycles.
REQ-034 SHALL cover: mode 1, d=0, fword=2^(PHASE_W-LUT_AW) -> output = c/2 stepping one LUT entry per cycle; peak 4095 at the quarter-period, trough -4096 at the three-quarter period.
REQ-035 SHALL cover: mode 2, d=15, in=-2048 for 512 cycles -> output equals -(c*1920)>>>11 per sample, saturated at 8191 where applicable, with no wrap glitch.
REQ-036 SHALL cover: config issued mid-period -> io_ctrl_ready low until the cycle after the next wrap; a second io_ctrl_valid while not ready is ignored; an accept coinciding with a wrap applies one full period later.
REQ-037 SHALL cover: mode 3, fword=0x010000, in sweeping sine 128-sample period, d=8 -> phase increment tracks fword+(m<<4) each cycle, modulo wrap correct at 2^24.
REQ-038 SHALL cover: reset pulsed for 1 cycle mid-stream with a pending config -> all outputs 0 asynchronously, io_ctrl_ready=1, pending config lost, io_out_valid returns 4 cycles after release.

Source files
------------

// File: rtl/tx_mod_core.sv
// tx_mod_core: baseband-to-DAC transmit modulator.
// A phase-accumulator NCO drives a sine table; the table output is combined
// with the held baseband sample in one of four modes (bypass, AM, DSB, FM),
// then shifted and saturated to the DAC width. Carrier configuration is
// double-buffered and only switches at a carrier phase wrap.
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous, active-high reset
//   io_ctrl_valid  config request
//   io_ctrl_ready  config slot free (no shadow pending)
//   io_ctrl_mode   0 bypass, 1 AM, 2 DSB, 3 FM
//   io_ctrl_depth  modulation depth d, unsigned
//   io_ctrl_fword  carrier frequency word
//   io_in_valid    new baseband sample present
//   io_in_value    signed baseband sample
//   io_out_valid   pipeline-filled flag
//   io_out_value   signed DAC sample
module tx_mod_core #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 14,
    parameter int PHASE_W  = 24,
    parameter int LUT_AW   = 8,
    parameter int DEPTH_W  = 4,
    parameter int FM_SHIFT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_ctrl_valid,
    output logic                      io_ctrl_ready,
    input  logic [1:0]                io_ctrl_mode,
    input  logic [DEPTH_W-1:0]        io_ctrl_depth,
    input  logic [PHASE_W-1:0]        io_ctrl_fword,
    input  logic                      io_in_valid,
    input  logic signed [IN_W-1:0]    io_in_value,
    output logic                      io_out_valid,
    output logic signed [OUT_W-1:0]   io_out_value
);

    localparam logic [1:0] MODE_BYP = 2'd0;
    localparam logic [1:0] MODE_AM  = 2'd1;
    localparam logic [1:0] MODE_DSB = 2'd2;
    localparam logic [1:0] MODE_FM  = 2'd3;

    localparam int N_LUT  = 2 ** LUT_AW;
    localparam int AMP    = (2 ** (OUT_W - 1)) - 1;
    localparam int PROD_W = OUT_W + IN_W + 2;
    localparam int SC_W   = IN_W + DEPTH_W + 1;

    localparam logic signed [IN_W+1:0]   AM_BIAS = (IN_W + 2)'(2 ** (IN_W - 1));
    localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'(AMP);
    localparam logic signed [PROD_W-1:0] OUT_MIN = ~OUT_MAX;

    // Elaboration-time sine: fold into the first quadrant so the series only
    // sees angles in [0, pi/2], then round half away from zero.
    function automatic int sine_entry(input int k);
        real x, term, s;
        int  kk, sgn;
        kk  = k;
        sgn = 1;
        if (kk >= N_LUT / 2) begin
            kk  = kk - N_LUT / 2;
            sgn = -1;
        end
        if (kk > N_LUT / 4) kk = N_LUT / 2 - kk;
        x    = 2.0 * 3.14159265358979323846 * real'(kk) / real'(N_LUT);
        term = x;
        s    = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        s = s * real'(AMP) * real'(sgn);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    endfunction

    // m = (sample * d) >>> DEPTH_W; |m| <= |sample| so IN_W bits always hold it.
    function automatic logic signed [IN_W-1:0] depth_scale(input logic signed [IN_W-1:0] s,
                                                           input logic [DEPTH_W-1:0] d);
        logic signed [SC_W-1:0] p;
        p = SC_W'(s) * SC_W'($signed({1'b0, d}));
        return p[DEPTH_W +: IN_W];
    endfunction

    function automatic logic signed [PROD_W-1:0] mix(input logic [1:0]              mode,
                                                     input logic signed [OUT_W-1:0] c,
                                                     input logic signed [IN_W-1:0]  m,
                                                     input logic signed [IN_W-1:0]  s);
        logic signed [IN_W+1:0] gain;
        gain = AM_BIAS + (IN_W + 2)'(m);
        case (mode)
            MODE_BYP: mix = PROD_W'(s) <<< (OUT_W - IN_W);
            MODE_AM:  mix = PROD_W'(c) * PROD_W'(gain);
            MODE_DSB: mix = PROD_W'(c) * PROD_W'(m);
            default:  mix = PROD_W'(c);
        endcase
    endfunction

    function automatic logic signed [OUT_W-1:0] scale_sat(input logic [1:0]               mode,
                                                          input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] v;
        case (mode)
            MODE_AM:  v = p >>> IN_W;
            MODE_DSB: v = p >>> (IN_W - 1);
            default:  v = p;
        endcase
        if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
        else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        else                  return v[OUT_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] lut [N_LUT];

    for (genvar k = 0; k < N_LUT; k++) begin : g_lut
        localparam int V = sine_entry(k);
        assign lut[k] = OUT_W'(V);
    end

    // Active and shadow configuration.
    logic [1:0]         mode_a, sh_mode;
    logic [DEPTH_W-1:0] depth_a, sh_depth;
    logic [PHASE_W-1:0] fword_a, sh_fword;
    logic               pending;

    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] m_ext, fm_dev, phase_inc;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap;

    logic signed [IN_W-1:0]   sample_r;
    logic signed [IN_W-1:0]   m_p0, samp_p0, m_p1, samp_p1;
    logic [1:0]               mode_p0, mode_p1, mode_p2;
    logic signed [OUT_W-1:0]  c_p1;
    logic signed [PROD_W-1:0] prod_p2;
    logic                     vld_p0, vld_p1, vld_p2;

    assign io_ctrl_ready = ~pending;

    always_comb begin
        m_ext     = {{(PHASE_W - IN_W){m_p0[IN_W-1]}}, m_p0};
        fm_dev    = m_ext << FM_SHIFT;
        phase_inc = fword_a + ((mode_a == MODE_FM) ? fm_dev : '0);
        phase_sum = {1'b0, phase_r} + {1'b0, phase_inc};
        wrap      = phase_sum[PHASE_W];
    end

    // An accept needs ready, so accept and apply never collide: a shadow taken
    // in a wrap cycle waits for the following wrap. A stopped carrier (fword 0)
    // never wraps, so its shadow applies straight away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_a   <= '0;
            depth_a  <= '0;
            fword_a  <= '0;
            sh_mode  <= '0;
            sh_depth <= '0;
            sh_fword <= '0;
            pending  <= 1'b0;
        end else if (io_ctrl_valid && io_ctrl_ready) begin
            sh_mode  <= io_ctrl_mode;
            sh_depth <= io_ctrl_depth;
            sh_fword <= io_ctrl_fword;
            pending  <= 1'b1;
        end else if (pending && (wrap || fword_a == '0)) begin
            mode_a   <= sh_mode;
            depth_a  <= sh_depth;
            fword_a  <= sh_fword;
            pending  <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_r     <= '0;
            phase_r      <= '0;
            m_p0         <= '0;
            samp_p0      <= '0;
            mode_p0      <= '0;
            c_p1         <= '0;
            m_p1         <= '0;
            samp_p1      <= '0;
            mode_p1      <= '0;
            prod_p2      <= '0;
            mode_p2      <= '0;
            io_out_value <= '0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            io_out_valid <= 1'b0;
        end else begin
            if (io_in_valid) sample_r <= io_in_value;
            // stage 1: depth-scaled sample
            m_p0    <= depth_scale(sample_r, depth_a);
            samp_p0 <= sample_r;
            mode_p0 <= mode_a;
            vld_p0  <= 1'b1;
            // stage 2: carrier lookup and phase advance
            c_p1    <= lut[phase_r[PHASE_W-1 -: LUT_AW]];
            phase_r <= phase_sum[PHASE_W-1:0];
            m_p1    <= m_p0;
            samp_p1 <= samp_p0;
            mode_p1 <= mode_p0;
            vld_p1  <= vld_p0;
            // stage 3: mode product
            prod_p2 <= mix(mode_p1, c_p1, m_p1, samp_p1);
            mode_p2 <= mode_p1;
            vld_p2  <= vld_p1;
            // stage 4: shift, saturate, output register
            io_out_value <= scale_sat(mode_p2, prod_p2);
            io_out_valid <= vld_p2;
        end
    end

endmodule
